// File: rtl/classifier_io_pkg.sv
// Shared defaults and FSM state encoding for the classifier sample sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package classifier_io_pkg;

    localparam int NUM_A_DEF      = 9;
    localparam int WIDTH_A_DEF    = 4;
    localparam int OUTWIDTH_DEF   = 22;
    localparam int SETTLE_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Counts the settle window after start; done pulses on the final settle edge.
// Latency: done asserts SETTLE_CYCLES-1 cycles after the cycle following start.
// Backpressure: none; a new start restarts the count.
module settle_timer
    import classifier_io_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    // SETTLE_CYCLES is expected in 1..255 so the terminal value fits the counter.
    localparam logic [SETTLE_CNT_W-1:0] CNT_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    active;

    assign done = active && (settle_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            active     <= 1'b0;
        end else if (start) begin
            settle_cnt <= '0;
            active     <= 1'b1;
        end else if (done) begin
            settle_cnt <= '0;
            active     <= 1'b0;
        end else if (active) begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/classifier_sample_sequencer.sv
// Packs attributes into inp, holds it for the settle window, captures clf_out; SAMPLE_CNT_EN adds sample_cnt.
// Latency: res_valid high SETTLE_CYCLES edges after the last attribute is accepted.
// Backpressure: attr_ready low outside LOAD; result held until res_valid & res_ready.
module classifier_sample_sequencer
    import classifier_io_pkg::*;
#(
    parameter int NUM_A         = NUM_A_DEF,
    parameter int WIDTH_A       = WIDTH_A_DEF,
    parameter int OUTWIDTH      = OUTWIDTH_DEF,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     attr_valid,
    input  logic [WIDTH_A-1:0]       attr_data,
    output logic                     attr_ready,
    output logic [NUM_A*WIDTH_A-1:0] inp,
    input  logic [OUTWIDTH-1:0]      clf_out,
    output logic                     res_valid,
    output logic [OUTWIDTH-1:0]      res_data,
    input  logic                     res_ready,
    output logic                     busy
`ifdef SAMPLE_CNT_EN
    ,
    output logic [15:0]              sample_cnt
`endif
);

    localparam int               IDX_W    = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_A - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_attr;
    logic             settle_done;
    logic             capture;
    logic             consume;

    assign accept    = attr_valid && attr_ready;
    assign last_attr = accept && (idx == IDX_LAST);
    assign capture   = (state == ST_SETTLE) && settle_done;
    assign consume   = res_valid && res_ready;
    assign busy      = (state != ST_LOAD) || (idx != '0);

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (last_attr),
        .done  (settle_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        attr_ready = 1'b0;
        res_valid  = 1'b0;
        case (state)
            ST_LOAD: begin
                attr_ready = 1'b1;
                if (attr_valid && (idx == IDX_LAST)) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // inp is never cleared between samples: slots not yet rewritten keep the prior sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            inp      <= '0;
            res_data <= '0;
        end else begin
            if (accept) begin
                inp[idx*WIDTH_A +: WIDTH_A] <= attr_data;
                idx                         <= last_attr ? '0 : idx + IDX_ONE;
            end
            if (capture) begin
                res_data <= clf_out;
            end
        end
    end

`ifdef SAMPLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (consume) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end
`else
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_classifier_sample_sequencer.sv
// Directed bench: packing, settle latency, backpressure, gapped input, async reset, SETTLE_CYCLES=1 instance.
// The classifier core is emulated as clf_out = inp[21:0] ^ 22'h2A5A5A ^ clf_xor.
module tb_classifier_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        attr_valid;
    logic [3:0]  attr_data;
    logic        attr_ready;
    logic [35:0] inp;
    logic [21:0] clf_out;
    logic        res_valid;
    logic [21:0] res_data;
    logic        res_ready;
    logic        busy;
    logic [21:0] clf_xor;

    logic        attr_valid_s1;
    logic        attr_ready_s1;
    logic [35:0] inp_s1;
    logic        res_valid_s1;
    logic [21:0] res_data_s1;
    logic        busy_s1;
`ifdef SAMPLE_CNT_EN
    logic [15:0] sample_cnt;
    logic [15:0] sample_cnt_s1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign clf_out = inp[21:0] ^ 22'h2A5A5A ^ clf_xor;

    classifier_sample_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .attr_valid (attr_valid),
        .attr_data  (attr_data),
        .attr_ready (attr_ready),
        .inp        (inp),
        .clf_out    (clf_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy)
`ifdef SAMPLE_CNT_EN
        ,
        .sample_cnt (sample_cnt)
`endif
    );

    classifier_sample_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .attr_valid (attr_valid_s1),
        .attr_data  (4'h5),
        .attr_ready (attr_ready_s1),
        .inp        (inp_s1),
        .clf_out    (22'h12345),
        .res_valid  (res_valid_s1),
        .res_data   (res_data_s1),
        .res_ready  (1'b1),
        .busy       (busy_s1)
`ifdef SAMPLE_CNT_EN
        ,
        .sample_cnt (sample_cnt_s1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offers one attribute from a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [3:0] d, input int gap);
        int n;
        attr_valid = 1'b0;
        repeat (gap) @(negedge clk);
        attr_valid = 1'b1;
        attr_data  = d;
        n = 0;
        while (!attr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!attr_ready) begin
            chk("attr_ready_wait", 64'(attr_ready), 64'h1);
        end else begin
            @(negedge clk);
        end
        attr_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic full_sample(input string tag);
        int lat;
        for (int i = 1; i <= 9; i++) send(4'(i), 0);
        chk({tag, "_inp"}, 64'(inp), 64'h9_8765_4321);
        chk({tag, "_busy_settle"}, 64'(busy), 64'h1);
        chk({tag, "_ready_settle"}, 64'(attr_ready), 64'h0);
        wait_result(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_res_data"}, 64'(res_data), 64'h0F197B);
        @(negedge clk);
        chk({tag, "_valid_one_cycle"}, 64'(res_valid), 64'h0);
        chk({tag, "_ready_back"}, 64'(attr_ready), 64'h1);
        chk({tag, "_busy_idle"}, 64'(busy), 64'h0);
    endtask

    initial begin
        int lat;
        int bad;
        int m;
        rst_n         = 1'b0;
        attr_valid    = 1'b0;
        attr_data     = 4'h0;
        res_ready     = 1'b1;
        clf_xor       = '0;
        attr_valid_s1 = 1'b0;

        #12;
        chk("rst_inp", 64'(inp), 64'h0);
        chk("rst_res_data", 64'(res_data), 64'h0);
        chk("rst_res_valid", 64'(res_valid), 64'h0);
        chk("rst_attr_ready", 64'(attr_ready), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        full_sample("s1");

        // Gapped F/0 sample with the result stalled.
        res_ready = 1'b0;
        for (int i = 0; i < 9; i++) send((i % 2 == 0) ? 4'hF : 4'h0, $urandom_range(0, 2));
        chk("gap_inp", 64'(inp), 64'hF_0F0F_0F0F);
        wait_result(lat);
        chk("gap_latency", 64'(lat), 64'd4);
        chk("gap_res_data", 64'(res_data), 64'h255555);
        clf_xor    = 22'h3FFFFF;
        attr_valid = 1'b1;
        attr_data  = 4'h7;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_data !== 22'h255555 || inp !== 36'hF_0F0F_0F0F || attr_ready !== 1'b0 || res_valid !== 1'b1)
                bad++;
        end
        chk("bp_stable_cycles", 64'(bad), 64'd0);
        chk("bp_res_valid", 64'(res_valid), 64'h1);
        attr_valid = 1'b0;
        res_ready  = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(res_valid), 64'h0);
        chk("bp_release_ready", 64'(attr_ready), 64'h1);
        chk("bp_idx_untouched", 64'(busy), 64'h0);
        clf_xor = '0;

        // Partial sample overwrites only slot 0.
        send(4'h3, 0);
        chk("partial_inp", 64'(inp), 64'hF_0F0F_0F03);
        for (int i = 4; i <= 7; i++) send(4'(i), 0);
        chk("partial5_busy", 64'(busy), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_inp", 64'(inp), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_res_valid", 64'(res_valid), 64'h0);
        chk("midrst_attr_ready", 64'(attr_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        full_sample("s2");
`ifdef SAMPLE_CNT_EN
        chk("sample_cnt", 64'(sample_cnt), 64'd1);
`endif

        // SETTLE_CYCLES=1 instance: continuous input and result acceptance.
        attr_valid_s1 = 1'b1;
        m = 0;
        while (!res_valid_s1 && m < 40) begin
            @(negedge clk);
            m++;
        end
        chk("st1_first_result", 64'(m), 64'd10);
        chk("st1_res_data", 64'(res_data_s1), 64'h12345);
        chk("st1_inp", 64'(inp_s1), 64'h5_5555_5555);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!res_valid_s1 && m < 40);
        chk("st1_period", 64'(m), 64'd11);
        attr_valid_s1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
